ula_seq: RTL and testbench

- Parametrised, registered successor to the team's 8-bit combinational ALU.
- Adds a WIDTH parameter, a valid/ready handshake on both input and output, and registered status flags (Z, C, N, V).
- Adds an iterative multi-cycle multiply.
- Sits between the datapath operand registers and the writeback stage; accepts one operation at a time.

---
 rtl/ula_seq.sv | 193 +++++++++++++++++++
 tb/tb_ula_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ula_seq.sv
// ula_seq: registered ALU with valid/ready handshake, status flags {Z,C,N,V}
// and an iterative shift-add multiply (one partial product per cycle).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a new operation (in_ready = 1)
// BUSY  | multiply in progress, one shift-add step per cycle (busy = 1)
// DONE  | result and status presented (out_valid = 1) until out_ready
module ula_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic [3:0]       status,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic [3:0]         status_q, status_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [WIDTH:0]     sum, diff, shl_ext, shr_ext;
    logic [WIDTH-1:0]   alu_r;
    logic               alu_c, alu_v;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH-1:0]   mul_lo, mul_hi;

    function automatic logic [3:0] flags(input logic [WIDTH-1:0] res,
                                         input logic c, input logic v);
        return {(res == '0), c, res[WIDTH-1], v};
    endfunction

    // Single-cycle ops evaluated straight from the inputs at the accept edge.
    // Shifts use one guard bit so the last bit shifted out lands in a fixed
    // position; oversized shift amounts naturally yield zero result and carry.
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        shl_ext = {1'b0, a} << b;
        shr_ext = {a, 1'b0} >> b;
        alu_r   = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            3'd0: begin
                alu_r = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            3'd1: begin
                alu_r = diff[WIDTH-1:0];
                alu_c = diff[WIDTH];
                alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            3'd2: begin
                alu_r = shl_ext[WIDTH-1:0];
                alu_c = shl_ext[WIDTH];
            end
            3'd3: begin
                alu_r = shr_ext[WIDTH:1];
                alu_c = shr_ext[0];
            end
            3'd4:    alu_r = a & b;
            3'd5:    alu_r = a | b;
            3'd6:    alu_r = ~(a | b);
            default: alu_r = '0;
        endcase
    end

    // One multiply step: add the multiplicand shifted by the step index when
    // the current multiplier LSB is set (multiplier shifts right each step).
    always_comb begin
        mul_next = acc_q + (b_q[0] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0);
        mul_lo   = mul_next[WIDTH-1:0];
        mul_hi   = mul_next[2*WIDTH-1:WIDTH];
    end

    // Next-state and registered-output logic for the IDLE/BUSY/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        status_d    = status_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = a;
                    b_d        = b;
                    in_ready_d = 1'b0;
                    if (op == 3'd7) begin
                        state_d = S_BUSY;
                        busy_d  = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                        r_d         = alu_r;
                        status_d    = flags(alu_r, alu_c, alu_v);
                    end
                end
            end
            S_BUSY: begin
                acc_d = mul_next;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d     = S_DONE;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
                    r_d         = mul_lo;
                    status_d    = flags(mul_lo, |mul_hi, 1'b0);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            r_q         <= '0;
            status_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            status_q    <= status_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign r         = r_q;
    assign status    = status_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ula_seq.sv
// Directed testbench for ula_seq at WIDTH = 8.
module tb_ula_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] op_i = 3'd0;
    logic [7:0] a_i = 8'h00;
    logic [7:0] b_i = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] r;
    logic [3:0] status;
    logic       busy;

    int checks = 0;
    int errors = 0;

    ula_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op_i),
        .a         (a_i),
        .b         (b_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .status    (status),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] er;
        logic [3:0] es;   // {Z,C,N,V}
        logic [3:0] elat;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one operation, scramble inputs after accept, wait for out_valid,
    // then drain the result. Returns result, status, latency and whether
    // busy/in_ready behaved during the wait.
    task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] rr, output logic [3:0] ss,
                         output int lat, output int bad_busy);
        @(negedge clk);
        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        op_i = op;
        a_i = a;
        b_i = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_i = ~op;
        a_i = ~a;
        b_i = b ^ 8'h5A;
        lat = 0;
        bad_busy = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = n;
                break;
            end
            if (!busy || in_ready) bad_busy++;
        end
        rr = r;
        ss = status;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("idle_after_drain_in_ready", {31'd0, in_ready}, 32'd1);
        chk("idle_after_drain_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [7:0] rr;
        logic [3:0] ss;
        int lat;
        int bad;

        //             op    a      b      r      {ZCNV} lat
        vecs[0]  = '{3'd0, 8'h7F, 8'h01, 8'h80, 4'h3, 4'd1};
        vecs[1]  = '{3'd0, 8'hFF, 8'h01, 8'h00, 4'hC, 4'd1};
        vecs[2]  = '{3'd0, 8'h40, 8'h40, 8'h80, 4'h3, 4'd1};
        vecs[3]  = '{3'd1, 8'h05, 8'h07, 8'hFE, 4'h6, 4'd1};
        vecs[4]  = '{3'd1, 8'h80, 8'h01, 8'h7F, 4'h1, 4'd1};
        vecs[5]  = '{3'd1, 8'h33, 8'h33, 8'h00, 4'h8, 4'd1};
        vecs[6]  = '{3'd2, 8'h81, 8'h01, 8'h02, 4'h4, 4'd1};
        vecs[7]  = '{3'd2, 8'h81, 8'h09, 8'h00, 4'h8, 4'd1};
        vecs[8]  = '{3'd2, 8'h81, 8'h08, 8'h00, 4'hC, 4'd1};
        vecs[9]  = '{3'd3, 8'h81, 8'h01, 8'h40, 4'h4, 4'd1};
        vecs[10] = '{3'd3, 8'h81, 8'h00, 8'h81, 4'h2, 4'd1};
        vecs[11] = '{3'd3, 8'h81, 8'h08, 8'h00, 4'hC, 4'd1};
        vecs[12] = '{3'd4, 8'hF0, 8'h3C, 8'h30, 4'h0, 4'd1};
        vecs[13] = '{3'd5, 8'hF0, 8'h0F, 8'hFF, 4'h2, 4'd1};
        vecs[14] = '{3'd6, 8'hF0, 8'h0F, 8'h00, 4'h8, 4'd1};
        vecs[15] = '{3'd6, 8'h00, 8'h00, 8'hFF, 4'h2, 4'd1};
        vecs[16] = '{3'd7, 8'h10, 8'h11, 8'h10, 4'h4, 4'd9};
        vecs[17] = '{3'd7, 8'h00, 8'hFF, 8'h00, 4'h8, 4'd9};
        vecs[18] = '{3'd7, 8'hFF, 8'hFF, 8'h01, 4'h4, 4'd9};
        vecs[19] = '{3'd7, 8'h0F, 8'h0F, 8'hE1, 4'h2, 4'd9};

        // Reset state
        #12;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_r", {24'd0, r}, 32'd0);
        chk("reset_status", {28'd0, status}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < NV; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, rr, ss, lat, bad);
            chk($sformatf("v%0d_r", i), {24'd0, rr}, {24'd0, vecs[i].er});
            chk($sformatf("v%0d_status", i), {28'd0, ss}, {28'd0, vecs[i].es});
            chk($sformatf("v%0d_latency", i), lat, {28'd0, vecs[i].elat});
            chk($sformatf("v%0d_busy_window", i), bad, 0);
        end

        // Backpressure: hold result for 5 cycles with a competing request
        @(negedge clk);
        in_valid = 1'b1; op_i = 3'd0; a_i = 8'h7F; b_i = 8'h01;
        @(posedge clk);
        #1;
        op_i = 3'd0; a_i = 8'h01; b_i = 8'h01;
        @(negedge clk);
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_r", k), {24'd0, r}, 32'h80);
            chk($sformatf("bp%0d_status", k), {28'd0, status}, 32'h3);
            chk($sformatf("bp%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
            chk($sformatf("bp%0d_out_valid", k), {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (3) @(negedge clk);
        chk("bp_request_not_latched", {31'd0, out_valid}, 32'd0);

        // Reset during a multiply
        @(negedge clk);
        in_valid = 1'b1; op_i = 3'd7; a_i = 8'h10; b_i = 8'h11;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_mul_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_r", {24'd0, r}, 32'd0);
        chk("rst_mid_status", {28'd0, status}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        do_op(3'd0, 8'h01, 8'h01, rr, ss, lat, bad);
        chk("post_rst_add_r", {24'd0, rr}, 32'h02);
        chk("post_rst_add_status", {28'd0, ss}, 32'h0);
        chk("post_rst_add_latency", lat, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
